// File: rtl/weight_stream_sink.sv
// Stream-to-RAM capture sink for weight/bias sources.
// Packs each accepted beat into one word; 2-stage ROM-style read port.
module weight_stream_sink #(
    parameter int PRECISION_0       = 16,
    parameter int PRECISION_1       = 3,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH          = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    parameter int CONTINUOUS        = 0,
    parameter int ADDR_WIDTH        = $clog2(IN_DEPTH) + 1,
    localparam int P = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int W = PRECISION_0 * P
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION_0-1:0] data_in [P-1:0],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   clear,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_ce,
    output logic [W-1:0]           rd_q,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  beat_count,
    output logic [15:0]            pass_count
);

    localparam int MAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(IN_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(IN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    // Fraction width is purely descriptive but must still fit the element.
    if (PRECISION_1 > PRECISION_0) begin : g_bad_frac
        $error("PRECISION_1 exceeds PRECISION_0");
    end

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] beat_q, beat_d;
    logic [15:0]           pass_q, pass_d;
    logic                  done_q, done_d;
    logic [W-1:0]          t0_q;
    logic [W-1:0]          rdo_q;
    logic [W-1:0]          mem [IN_DEPTH];
    logic [W-1:0]          beat_w;
    logic                  xfer;
    logic                  last;

    always_comb begin
        beat_w = '0;
        for (int j = 0; j < P; j++) begin
            beat_w[PRECISION_0*j +: PRECISION_0] = data_in[j];
        end
    end

    assign data_in_ready = (state_q == FILL) && rst;
    assign xfer          = data_in_valid && data_in_ready;
    assign last          = (wr_ptr_q == LAST_A);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            beat_q   <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            beat_q   <= beat_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        beat_d   = beat_q;
        pass_d   = pass_q;
        // Continuous mode turns done into a single-cycle pulse.
        done_d   = (CONTINUOUS != 0) ? 1'b0 : done_q;
        if (clear) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            beat_d   = '0;
            done_d   = 1'b0;
        end else if (xfer) begin
            if (last) begin
                wr_ptr_d = '0;
                done_d   = 1'b1;
                if (pass_q != 16'hFFFF) begin
                    pass_d = pass_q + 16'd1;
                end
                if (CONTINUOUS != 0) begin
                    beat_d = '0;
                end else begin
                    beat_d  = beat_q + ONE_A;
                    state_d = FULL;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + ONE_A;
                beat_d   = beat_q + ONE_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && !clear) begin
            mem[wr_ptr_q[MAW-1:0]] <= beat_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            t0_q  <= '0;
            rdo_q <= '0;
        end else if (rd_ce) begin
            t0_q  <= (rd_addr < DEPTH_A) ? mem[rd_addr[MAW-1:0]] : '0;
            rdo_q <= t0_q;
        end
    end

    assign rd_q       = rdo_q;
    assign done       = done_q;
    assign beat_count = beat_q;
    assign pass_count = pass_q;

endmodule

// File: tb/tb_weight_stream_sink.sv
// Bench for weight_stream_sink: default one-shot instance plus a
// 4-wide continuous instance, checked against a tensor-level model.
module tb_weight_stream_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 0: defaults (P=1, IN_DEPTH=32, one-shot)
    logic [15:0] din0 [0:0];
    logic        valid0, ready0, clear0, rd_ce0, done0;
    logic [5:0]  rd_addr0, bc0;
    logic [15:0] rd_q0, pc0;

    // Instance 1: P=4, IN_DEPTH=4, continuous
    logic [15:0] din1 [3:0];
    logic        valid1, ready1, clear1, rd_ce1, done1;
    logic [2:0]  rd_addr1, bc1;
    logic [63:0] rd_q1;
    logic [15:0] pc1;

    weight_stream_sink u_d0 (
        .clk(clk), .rst(rst),
        .data_in(din0), .data_in_valid(valid0), .data_in_ready(ready0),
        .clear(clear0), .rd_addr(rd_addr0), .rd_ce(rd_ce0), .rd_q(rd_q0),
        .done(done0), .beat_count(bc0), .pass_count(pc0)
    );

    weight_stream_sink #(
        .TENSOR_SIZE_DIM_0(16), .PARALLELISM_DIM_0(4), .CONTINUOUS(1)
    ) u_d1 (
        .clk(clk), .rst(rst),
        .data_in(din1), .data_in_valid(valid1), .data_in_ready(ready1),
        .clear(clear1), .rd_addr(rd_addr1), .rd_ce(rd_ce1), .rd_q(rd_q1),
        .done(done1), .beat_count(bc1), .pass_count(pc1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] exp;
    } rdvec_t;

    rdvec_t      rv [6];
    logic [15:0] model_mem [32];
    int          mcount;
    logic [15:0] cur, q16;
    logic [63:0] q64;
    bit          acc;
    int          pulses;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic read0(input logic [5:0] a, output logic [15:0] q);
        rd_addr0 = a;
        rd_ce0   = 1'b1;
        step();
        step();
        rd_ce0 = 1'b0;
        q = rd_q0;
    endtask

    task automatic read1(input logic [2:0] a, output logic [63:0] q);
        rd_addr1 = a;
        rd_ce1   = 1'b1;
        step();
        step();
        rd_ce1 = 1'b0;
        q = rd_q1;
    endtask

    // Word at addr after n beats of the 4-wide stream, beat k = {4k+3..4k}.
    function automatic logic [63:0] exp_word1(input int addr, input int n);
        logic [63:0] w;
        int k;
        w = '0;
        k = -1;
        for (int b = 0; b < n; b++) begin
            if (b % 4 == addr) k = b;
        end
        for (int j = 0; j < 4; j++) begin
            w[16*j +: 16] = 16'(4 * k + j);
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        rv[0] = '{6'd0,  16'd0};
        rv[1] = '{6'd5,  16'd15};
        rv[2] = '{6'd31, 16'd93};
        rv[3] = '{6'd32, 16'd0};
        rv[4] = '{6'd33, 16'd0};
        rv[5] = '{6'd63, 16'd0};

        rst = 1'b0;
        valid0 = 0; clear0 = 0; rd_ce0 = 0; rd_addr0 = 0; din0[0] = 0;
        valid1 = 0; clear1 = 0; rd_ce1 = 0; rd_addr1 = 0;
        for (int j = 0; j < 4; j++) din1[j] = '0;

        step();
        chk("ready_in_reset", ready0, 0);
        step();
        rst = 1'b1;
        #1;
        chk("rst_ready", ready0, 1);
        chk("rst_done", done0, 0);
        chk("rst_bc", bc0, 0);
        chk("rst_pc", pc0, 0);
        chk("rst_rdq", rd_q0, 0);

        // Straight fill with addr*3
        for (int i = 0; i < 32; i++) begin
            valid0 = 1'b1;
            din0[0] = 16'(i * 3);
            if (ready0 !== 1'b1 || done0 !== 1'b0) begin
                chk("fill_ready", ready0, 1);
                chk("fill_done", done0, 0);
            end
            step();
        end
        valid0 = 1'b0;
        chk("full_ready", ready0, 0);
        chk("full_done", done0, 1);
        chk("full_bc", bc0, 32);
        chk("full_pc", pc0, 1);

        // Beat offered while FULL is ignored
        valid0 = 1'b1;
        din0[0] = 16'd999;
        step();
        valid0 = 1'b0;
        chk("full_ign_bc", bc0, 32);
        chk("full_ign_pc", pc0, 1);

        for (int i = 0; i < 6; i++) begin
            read0(rv[i].addr, q16);
            chk($sformatf("tbl_rd_%0d", rv[i].addr), q16, rv[i].exp);
        end

        // Clear together with a beat in FULL: beat dropped
        clear0 = 1'b1;
        valid0 = 1'b1;
        din0[0] = 16'h7777;
        step();
        clear0 = 1'b0;
        valid0 = 1'b0;
        chk("clr_ready", ready0, 1);
        chk("clr_bc", bc0, 0);
        chk("clr_done", done0, 0);
        chk("clr_pc", pc0, 1);

        // Random valid pattern, data held across gaps
        mcount = 0;
        acc = 1'b1;
        cur = 16'h0;
        for (int cyc = 0; cyc < 3000 && mcount < 32; cyc++) begin
            if (acc) cur = 16'($urandom);
            valid0 = 1'($urandom_range(0, 1));
            din0[0] = cur;
            if (ready0 !== 1'b1) chk("rnd_ready", ready0, 1);
            acc = valid0;
            if (valid0) begin
                model_mem[mcount] = cur;
                mcount++;
            end
            step();
        end
        valid0 = 1'b0;
        chk("rnd_count", 64'(mcount), 32);
        chk("rnd_bc", bc0, 32);
        chk("rnd_pc", pc0, 2);
        chk("rnd_done", done0, 1);
        chk("rnd_ready_end", ready0, 0);
        for (int a = 0; a < 32; a++) begin
            read0(6'(a), q16);
            chk($sformatf("rnd_rd_%0d", a), q16, model_mem[a]);
        end
        read0(6'd33, q16);
        chk("rnd_rd_33", q16, 0);

        // Partial pass, reset, then fresh pass
        clear0 = 1'b1;
        step();
        clear0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid0 = 1'b1;
            din0[0] = 16'(1000 + i);
            step();
        end
        chk("part_bc", bc0, 10);
        rst = 1'b0;
        din0[0] = 16'd5555;
        #1;
        chk("rst_mid_ready", ready0, 0);
        step();
        rst = 1'b1;
        valid0 = 1'b0;
        #1;
        chk("rst_mid_bc", bc0, 0);
        chk("rst_mid_pc", pc0, 0);
        chk("rst_mid_ready1", ready0, 1);
        for (int i = 0; i < 32; i++) begin
            valid0 = 1'b1;
            din0[0] = 16'(2000 + i);
            if (i == 0) begin
                rd_addr0 = 6'd0;
                rd_ce0 = 1'b1;
            end
            if (done0 !== 1'b0) chk("post_rst_done_early", done0, 0);
            step();
            if (i == 1) begin
                chk("read_first", rd_q0, 1000);
                rd_ce0 = 1'b0;
            end
        end
        valid0 = 1'b0;
        step();
        chk("rdce_hold", rd_q0, 1000);
        chk("post_rst_done", done0, 1);
        chk("post_rst_pc", pc0, 1);
        chk("post_rst_bc", bc0, 32);
        read0(6'd0, q16);
        chk("post_rst_rd0", q16, 2000);
        read0(6'd9, q16);
        chk("post_rst_rd9", q16, 2009);

        // 4-wide continuous instance
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            valid1 = 1'b1;
            for (int j = 0; j < 4; j++) din1[j] = 16'(4 * k + j);
            if (ready1 !== 1'b1) chk("c_ready", ready1, 1);
            step();
            if (done1 !== ((k % 4) == 3)) begin
                chk($sformatf("c_done_%0d", k), done1, (k % 4) == 3);
            end
            if (done1) pulses++;
            if (k == 3) begin
                valid1 = 1'b0;
                chk("c_bc_wrap", bc1, 0);
                chk("c_pc1", pc1, 1);
                read1(3'd2, q64);
                chk("c_pack_rd2", q64, exp_word1(2, 4));
            end
        end
        valid1 = 1'b0;
        step();
        chk("c_done_low", done1, 0);
        chk("c_pulses", 64'(pulses), 2);
        chk("c_pc", pc1, 2);
        chk("c_bc", bc1, 2);
        read1(3'd2, q64);
        chk("c_ovw_rd2", q64, exp_word1(2, 10));
        read1(3'd1, q64);
        chk("c_ovw_rd1", q64, exp_word1(1, 10));
        read1(3'd3, q64);
        chk("c_rd3", q64, exp_word1(3, 10));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
